// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, ALU-code and FSM-state definitions for the sequenced control unit.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {FETCH, EXEC, MUL_WAIT, HALTED} state_e;

   // Full-width opcodes take priority over the op4 field decode
   localparam logic [7:0] OPC_NOP = 8'h00;
   localparam logic [7:0] OPC_LSL = 8'h01;
   localparam logic [7:0] OPC_LSR = 8'h02;
   localparam logic [7:0] OPC_CIR = 8'h03;
   localparam logic [7:0] OPC_CIL = 8'h04;
   localparam logic [7:0] OPC_ASR = 8'h05;
   localparam logic [7:0] OPC_INC = 8'h06;
   localparam logic [7:0] OPC_DEC = 8'h07;
   localparam logic [7:0] OPC_HLT = 8'hFF;

   localparam logic [3:0] OP4_ADD   = 4'h1;
   localparam logic [3:0] OP4_SUB   = 4'h2;
   localparam logic [3:0] OP4_MUL   = 4'h3;
   localparam logic [3:0] OP4_AND   = 4'h5;
   localparam logic [3:0] OP4_XOR   = 4'h6;
   localparam logic [3:0] OP4_CMP   = 4'h7;
   localparam logic [3:0] OP4_BR    = 4'h8;
   localparam logic [3:0] OP4_MOVAR = 4'h9;
   localparam logic [3:0] OP4_MOVRA = 4'hA;
   localparam logic [3:0] OP4_RET   = 4'hB;
   localparam logic [3:0] OP4_CALL  = 4'hC;

   localparam logic [3:0] ALU_NOP = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0001;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_MUL = 4'b0011;
   localparam logic [3:0] ALU_LSL = 4'b0100;
   localparam logic [3:0] ALU_LSR = 4'b0101;
   localparam logic [3:0] ALU_CIR = 4'b0110;
   localparam logic [3:0] ALU_CIL = 4'b0111;
   localparam logic [3:0] ALU_ASR = 4'b1000;
   localparam logic [3:0] ALU_AND = 4'b1001;
   localparam logic [3:0] ALU_XOR = 4'b1010;
   localparam logic [3:0] ALU_CMP = 4'b1011;
   localparam logic [3:0] ALU_INC = 4'b1100;
   localparam logic [3:0] ALU_DEC = 4'b1101;
   localparam logic [3:0] ALU_MOV = 4'b1110;

endpackage

// File: rtl/seq_control_unit_ret_stack.sv
// Return-address stack: push/pop with full/empty status; top reads 0 when empty.
module ret_stack #(
   parameter int STACK_DEPTH = 4,
   parameter int PC_W        = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] din,
   output logic [PC_W-1:0] top,
   output logic            full,
   output logic            empty
);

   localparam int SP_W = $clog2(STACK_DEPTH + 1);

   logic [PC_W-1:0] mem_q [STACK_DEPTH];
   logic [PC_W-1:0] mem_d [STACK_DEPTH];
   logic [SP_W-1:0] sp_q, sp_d;

   assign full  = (sp_q == SP_W'(STACK_DEPTH));
   assign empty = (sp_q == '0);
   assign top   = empty ? '0 : mem_q[sp_q - SP_W'(1)];

   always_comb begin
      mem_d = mem_q;
      sp_d  = sp_q;
      if (push && !full) begin
         mem_d[sp_q] = din;
         sp_d        = sp_q + SP_W'(1);
      end else if (pop && !empty) begin
         sp_d = sp_q - SP_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q <= '0;
         for (int unsigned i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sp_q  <= sp_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle control unit: FETCH/EXEC/MUL_WAIT/HALTED sequencing, IR latch,
// strobe decode from the latched IR, stretched MUL and CALL/RET return stack.
module seq_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int INSTR_W     = 8,
   parameter int PC_W        = 8,
   parameter int STACK_DEPTH = 4,
   parameter int MUL_CYCLES  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               instr_valid,
   input  logic               cb_in,
   input  logic [PC_W-1:0]    pc_in,
   output logic               ir_load,
   output logic               rf_we,
   output logic [3:0]         alu_op,
   output logic               pc_load,
   output logic               pc_sel,
   output logic               pc_inc,
   output logic               acc_we,
   output logic               ext_we,
   output logic               cb_we,
   output logic [PC_W-1:0]    ret_addr,
   output logic               halt,
   output logic               stack_overflow,
   output logic               stack_underflow
);

   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d, unf_q, unf_d;
   logic               push, pop, stk_full, stk_empty;
   logic [3:0]         op4;

   assign op4             = ir_q[INSTR_W-1 -: 4];
   assign stack_overflow  = ovf_q;
   assign stack_underflow = unf_q;

   ret_stack #(.STACK_DEPTH(STACK_DEPTH), .PC_W(PC_W)) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (pc_in + PC_W'(1)),
      .top   (ret_addr),
      .full  (stk_full),
      .empty (stk_empty)
   );

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      pop     = 1'b0;
      ir_load = 1'b0;
      rf_we   = 1'b0;
      alu_op  = ALU_NOP;
      pc_load = 1'b0;
      pc_sel  = 1'b0;
      pc_inc  = 1'b0;
      acc_we  = 1'b0;
      ext_we  = 1'b0;
      cb_we   = 1'b0;
      halt    = 1'b0;
      unique case (state_q)
         FETCH: begin
            // gated by rst so no fetch strobe escapes while reset is held
            if (instr_valid && !rst) begin
               ir_load = 1'b1;
               ir_d    = instr_in;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = FETCH;
            case (ir_q)
               INSTR_W'(OPC_NOP): pc_inc = 1'b1;
               INSTR_W'(OPC_LSL): begin alu_op = ALU_LSL; acc_we = 1'b1; pc_inc = 1'b1; end
               INSTR_W'(OPC_LSR): begin alu_op = ALU_LSR; acc_we = 1'b1; pc_inc = 1'b1; end
               INSTR_W'(OPC_CIR): begin alu_op = ALU_CIR; acc_we = 1'b1; pc_inc = 1'b1; end
               INSTR_W'(OPC_CIL): begin alu_op = ALU_CIL; acc_we = 1'b1; pc_inc = 1'b1; end
               INSTR_W'(OPC_ASR): begin alu_op = ALU_ASR; acc_we = 1'b1; pc_inc = 1'b1; end
               INSTR_W'(OPC_INC): begin alu_op = ALU_INC; acc_we = 1'b1; cb_we = 1'b1; pc_inc = 1'b1; end
               INSTR_W'(OPC_DEC): begin alu_op = ALU_DEC; acc_we = 1'b1; cb_we = 1'b1; pc_inc = 1'b1; end
               INSTR_W'(OPC_HLT): state_d = HALTED;
               default: begin
                  case (op4)
                     OP4_ADD:   begin alu_op = ALU_ADD; acc_we = 1'b1; cb_we = 1'b1; pc_inc = 1'b1; end
                     OP4_SUB:   begin alu_op = ALU_SUB; acc_we = 1'b1; cb_we = 1'b1; pc_inc = 1'b1; end
                     OP4_AND:   begin alu_op = ALU_AND; acc_we = 1'b1; pc_inc = 1'b1; end
                     OP4_XOR:   begin alu_op = ALU_XOR; acc_we = 1'b1; pc_inc = 1'b1; end
                     OP4_CMP:   begin alu_op = ALU_CMP; cb_we = 1'b1; pc_inc = 1'b1; end
                     OP4_MOVAR: begin alu_op = ALU_MOV; acc_we = 1'b1; pc_inc = 1'b1; end
                     OP4_MOVRA: begin rf_we = 1'b1; pc_inc = 1'b1; end
                     OP4_BR: begin
                        pc_load = cb_in;
                        pc_inc  = !cb_in;
                     end
                     OP4_CALL: begin
                        if (!stk_full) begin
                           push    = 1'b1;
                           pc_load = 1'b1;
                        end else begin
                           ovf_d  = 1'b1;
                           pc_inc = 1'b1;
                        end
                     end
                     OP4_RET: begin
                        if (!stk_empty) begin
                           pop     = 1'b1;
                           pc_load = 1'b1;
                           pc_sel  = 1'b1;
                        end else begin
                           unf_d  = 1'b1;
                           pc_inc = 1'b1;
                        end
                     end
                     OP4_MUL: begin
                        alu_op = ALU_MUL;
                        if (MUL_CYCLES == 1) begin
                           acc_we = 1'b1;
                           ext_we = 1'b1;
                           pc_inc = 1'b1;
                        end else begin
                           state_d = MUL_WAIT;
                           cnt_d   = CNT_W'(MUL_CYCLES - 2);
                        end
                     end
                     default: pc_inc = 1'b1;
                  endcase
               end
            endcase
         end
         MUL_WAIT: begin
            alu_op = ALU_MUL;
            if (cnt_q == '0) begin
               acc_we  = 1'b1;
               ext_we  = 1'b1;
               pc_inc  = 1'b1;
               state_d = FETCH;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HALTED: halt = 1'b1;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         ir_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

endmodule

// File: tb/tb_seq_control_unit.sv
// Self-checking bench for seq_control_unit: directed vector table, multi-cycle
// corner sequences and random instruction streams against a queue-based model.
module tb_seq_control_unit;

   localparam int INSTR_W     = 8;
   localparam int PC_W        = 8;
   localparam int STACK_DEPTH = 4;
   localparam int MUL_CYCLES  = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [INSTR_W-1:0] instr_in = '0;
   logic               instr_valid = 1'b0;
   logic               cb_in = 1'b0;
   logic [PC_W-1:0]    pc_in = '0;
   logic               ir_load, rf_we, pc_load, pc_sel, pc_inc, acc_we, ext_we, cb_we;
   logic               halt, stack_overflow, stack_underflow;
   logic [3:0]         alu_op;
   logic [PC_W-1:0]    ret_addr;

   seq_control_unit #(
      .INSTR_W(INSTR_W), .PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH), .MUL_CYCLES(MUL_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
      .cb_in(cb_in), .pc_in(pc_in), .ir_load(ir_load), .rf_we(rf_we),
      .alu_op(alu_op), .pc_load(pc_load), .pc_sel(pc_sel), .pc_inc(pc_inc),
      .acc_we(acc_we), .ext_we(ext_we), .cb_we(cb_we), .ret_addr(ret_addr),
      .halt(halt), .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       ir_load;
      logic       rf_we;
      logic [3:0] alu_op;
      logic       pc_load;
      logic       pc_sel;
      logic       pc_inc;
      logic       acc_we;
      logic       ext_we;
      logic       cb_we;
      logic [7:0] ret_addr;
      logic       halt;
      logic       ovf;
      logic       unf;
   } obs_t;

   typedef struct {
      logic [7:0] ins;
      logic       cb;
      logic [7:0] pc;
      obs_t       exp;
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_stack[$];
   bit         m_ovf, m_unf;
   obs_t       exp_q[$];

   function automatic obs_t actual();
      return {ir_load, rf_we, alu_op, pc_load, pc_sel, pc_inc, acc_we, ext_we,
              cb_we, ret_addr, halt, stack_overflow, stack_underflow};
   endfunction

   function automatic obs_t base();
      obs_t e = '0;
      e.ret_addr = (m_stack.size() > 0) ? m_stack[$] : 8'h00;
      e.ovf = m_ovf;
      e.unf = m_unf;
      return e;
   endfunction

   function automatic obs_t mk(logic rf, logic [3:0] alu, logic ld, logic sel, logic inc,
                               logic acc, logic cbw, logic [7:0] ret);
      obs_t e = '0;
      e.rf_we = rf; e.alu_op = alu; e.pc_load = ld; e.pc_sel = sel; e.pc_inc = inc;
      e.acc_we = acc; e.cb_we = cbw; e.ret_addr = ret;
      return e;
   endfunction

   task automatic check(input string name, input obs_t exp);
      obs_t act = actual();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (ir rf alu ld sel inc acc ext cbw ret halt ovf unf)",
                  name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected EXEC-phase outputs derived from the instruction-set rules.
   task automatic model_exec(input logic [7:0] ins, input logic cb, input logic [7:0] pc);
      obs_t e = base();
      logic [3:0] op4 = ins[7:4];
      bit set_ovf = 0, set_unf = 0;
      if (ins == 8'hFF) begin
         exp_q.push_back(e);
         return;
      end
      if (ins <= 8'h07) begin
         if (ins == 8'h00) e.pc_inc = 1;
         else if (ins <= 8'h05) begin e.alu_op = 4'(ins + 3); e.acc_we = 1; e.pc_inc = 1; end
         else begin e.alu_op = 4'(ins + 6); e.acc_we = 1; e.cb_we = 1; e.pc_inc = 1; end
         exp_q.push_back(e);
         return;
      end
      case (op4)
         4'h1, 4'h2: begin e.alu_op = op4; e.acc_we = 1; e.cb_we = 1; e.pc_inc = 1; end
         4'h5, 4'h6: begin e.alu_op = op4 + 4'd4; e.acc_we = 1; e.pc_inc = 1; end
         4'h7: begin e.alu_op = 4'hB; e.cb_we = 1; e.pc_inc = 1; end
         4'h9: begin e.alu_op = 4'hE; e.acc_we = 1; e.pc_inc = 1; end
         4'hA: begin e.rf_we = 1; e.pc_inc = 1; end
         4'h8: begin e.pc_load = cb; e.pc_inc = !cb; end
         4'hC: begin
            if (m_stack.size() < STACK_DEPTH) begin
               e.pc_load = 1;
               m_stack.push_back(pc + 8'd1);
            end else begin
               e.pc_inc = 1; set_ovf = 1;
            end
         end
         4'hB: begin
            if (m_stack.size() > 0) begin
               e.pc_load = 1; e.pc_sel = 1;
               void'(m_stack.pop_back());
            end else begin
               e.pc_inc = 1; set_unf = 1;
            end
         end
         4'h3: begin
            e.alu_op = 4'h3;
            for (int k = 1; k < MUL_CYCLES; k++) exp_q.push_back(e);
            e.acc_we = 1; e.ext_we = 1; e.pc_inc = 1;
         end
         default: e.pc_inc = 1;
      endcase
      exp_q.push_back(e);
      if (set_ovf) m_ovf = 1;
      if (set_unf) m_unf = 1;
   endtask

   task automatic do_reset(input string name);
      instr_valid = 1'b1;
      instr_in    = 8'h13;
      rst         = 1'b1;
      #1;
      @(negedge clk);
      check(name, obs_t'('0));
      tick();
      rst = 1'b0;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
      exp_q.delete();
      instr_valid = 1'b0;
   endtask

   task automatic do_instr(input logic [7:0] ins, input logic cb, input logic [7:0] pc,
                           input int idle, input bit use_tab, input obs_t texp,
                           input string name);
      obs_t e;
      for (int i = 0; i < idle; i++) begin
         instr_valid = 1'b0;
         instr_in    = 8'($urandom);
         @(negedge clk);
         check({name, "_idle"}, base());
         tick();
      end
      instr_valid = 1'b1;
      instr_in    = ins;
      cb_in       = cb;
      pc_in       = pc;
      e = base();
      e.ir_load = 1;
      @(negedge clk);
      check({name, "_fetch"}, e);
      model_exec(ins, cb, pc);
      tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (use_tab) e = texp;
         instr_valid = 1'($urandom);
         instr_in    = 8'($urandom);
         @(negedge clk);
         check({name, "_exec"}, e);
         tick();
      end
   endtask

   vec_t vecs[20];

   initial begin
      obs_t e;
      logic [7:0] ins;

      vecs[0]  = '{8'h13, 1'b0, 8'h00, mk(0, 4'h1, 0, 0, 1, 1, 1, 8'h00)};
      vecs[1]  = '{8'h2A, 1'b1, 8'h01, mk(0, 4'h2, 0, 0, 1, 1, 1, 8'h00)};
      vecs[2]  = '{8'h01, 1'b0, 8'h02, mk(0, 4'h4, 0, 0, 1, 1, 0, 8'h00)};
      vecs[3]  = '{8'h05, 1'b0, 8'h03, mk(0, 4'h8, 0, 0, 1, 1, 0, 8'h00)};
      vecs[4]  = '{8'h06, 1'b0, 8'h04, mk(0, 4'hC, 0, 0, 1, 1, 1, 8'h00)};
      vecs[5]  = '{8'h07, 1'b0, 8'h05, mk(0, 4'hD, 0, 0, 1, 1, 1, 8'h00)};
      vecs[6]  = '{8'h5F, 1'b0, 8'h06, mk(0, 4'h9, 0, 0, 1, 1, 0, 8'h00)};
      vecs[7]  = '{8'h61, 1'b0, 8'h07, mk(0, 4'hA, 0, 0, 1, 1, 0, 8'h00)};
      vecs[8]  = '{8'h73, 1'b0, 8'h08, mk(0, 4'hB, 0, 0, 1, 0, 1, 8'h00)};
      vecs[9]  = '{8'h92, 1'b0, 8'h09, mk(0, 4'hE, 0, 0, 1, 1, 0, 8'h00)};
      vecs[10] = '{8'hA4, 1'b0, 8'h0A, mk(1, 4'h0, 0, 0, 1, 0, 0, 8'h00)};
      vecs[11] = '{8'h00, 1'b0, 8'h0B, mk(0, 4'h0, 0, 0, 1, 0, 0, 8'h00)};
      vecs[12] = '{8'hD3, 1'b0, 8'h0C, mk(0, 4'h0, 0, 0, 1, 0, 0, 8'h00)};
      vecs[13] = '{8'h08, 1'b0, 8'h0D, mk(0, 4'h0, 0, 0, 1, 0, 0, 8'h00)};
      vecs[14] = '{8'h80, 1'b1, 8'h0E, mk(0, 4'h0, 1, 0, 0, 0, 0, 8'h00)};
      vecs[15] = '{8'h80, 1'b0, 8'h0F, mk(0, 4'h0, 0, 0, 1, 0, 0, 8'h00)};
      vecs[16] = '{8'hC0, 1'b0, 8'h10, mk(0, 4'h0, 1, 0, 0, 0, 0, 8'h00)};
      vecs[17] = '{8'hB0, 1'b0, 8'h20, mk(0, 4'h0, 1, 1, 0, 0, 0, 8'h11)};
      vecs[18] = '{8'h00, 1'b0, 8'h21, mk(0, 4'h0, 0, 0, 1, 0, 0, 8'h00)};
      vecs[19] = '{8'h03, 1'b0, 8'h22, mk(0, 4'h6, 0, 0, 1, 1, 0, 8'h00)};

      #2;
      do_reset("reset_initial");

      foreach (vecs[i])
         do_instr(vecs[i].ins, vecs[i].cb, vecs[i].pc, 0, 1, vecs[i].exp, $sformatf("vec%0d", i));

      // MUL stretch, followed immediately by another fetch
      do_instr(8'h35, 1'b0, 8'h30, 0, 0, '0, "mul");
      do_instr(8'h13, 1'b0, 8'h31, 0, 0, '0, "after_mul");

      // return stack overflow then underflow
      do_reset("reset_stack");
      for (int k = 0; k < 5; k++) do_instr(8'hC0, 1'b0, 8'(8'h20 + k), 0, 0, '0, $sformatf("call%0d", k));
      check_bit("ovf_sticky", stack_overflow, 1'b1);
      check_bit("unf_clear", stack_underflow, 1'b0);
      for (int k = 0; k < 5; k++) do_instr(8'hB0, 1'b0, 8'h40, 0, 0, '0, $sformatf("ret%0d", k));
      check_bit("unf_sticky", stack_underflow, 1'b1);
      check_bit("ovf_still", stack_overflow, 1'b1);

      // reset during MUL_WAIT: no acc_we pulse, back to FETCH
      do_reset("reset_premul");
      instr_valid = 1'b1;
      instr_in    = 8'h35;
      e = base(); e.ir_load = 1;
      @(negedge clk);
      check("mulrst_fetch", e);
      tick();
      instr_valid = 1'b0;
      e = base(); e.alu_op = 4'h3;
      @(negedge clk);
      check("mulrst_exec", e);
      tick();
      @(negedge clk);
      check("mulrst_wait", e);
      #1;
      do_reset("mulrst_reset");
      instr_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("mulrst_after", obs_t'('0));
         tick();
      end

      // randomized instruction stream
      do_reset("reset_rand");
      for (int i = 0; i < 300; i++) begin
         ins = {4'($urandom_range(0, 15)), 4'($urandom)};
         if ($urandom_range(0, 3) == 0) ins = 8'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) ins = ($urandom_range(0, 1) == 1) ? 8'hC5 : 8'hB2;
         if (ins == 8'hFF) ins = 8'h00;
         do_instr(ins, 1'($urandom), 8'($urandom), $urandom_range(0, 2), 0, '0, "rand");
         if (i % 60 == 59) do_reset("reset_rand_mid");
      end

      // halt is permanent until reset
      do_instr(8'h50, 1'b0, 8'h00, 0, 0, '0, "pre_hlt");
      do_instr(8'hC0, 1'b0, 8'h44, 0, 0, '0, "pre_hlt_call");
      do_instr(8'hFF, 1'b0, 8'h46, 0, 0, '0, "hlt");
      for (int i = 0; i < 10; i++) begin
         instr_valid = 1'b1;
         instr_in    = 8'($urandom);
         e = base(); e.halt = 1;
         @(negedge clk);
         check("halted", e);
         tick();
      end
      do_reset("reset_from_halt");
      @(negedge clk);
      check("post_halt_idle", obs_t'('0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish (checks %0d)", checks);
      $fatal(1);
   end

endmodule
